// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_queue.sv
// Circular prefetch buffer of {pc, word} entries with flush.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; when full, a same-cycle pop frees the slot being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch PC register, queue push/pop/redirect control and misalignment flag.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_dout,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  input  logic              instr_ready,
  output logic              misalign_err
);

  logic [31:0]  fetch_pc;
  logic         push;
  logic         pop;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  assign im_addr     = fetch_pc[ADDR_W-1:0];
  assign instr_valid = !q_empty;
  assign pop         = instr_valid && instr_ready;
  assign push        = !redirect_valid && (!q_full || pop);
  assign wr_entry    = '{pc: fetch_pc, word: im_dout};

  // Empty head is masked so uninitialised storage never reaches decode.
  assign instr    = q_empty ? NOP_INSTR : head.word;
  assign instr_pc = q_empty ? 32'h0     : head.pc;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .head     (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc     <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid)
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (push)
        fetch_pc <= fetch_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit against a queue-based reference model.
module tb_ifetch_unit;

  localparam int          ADDR_W   = 14;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_dout;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_ready = 1'b0;
  logic              misalign_err;

  logic [31:0] imem [4096];
  ent_t        mq [$];
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] dut_log [$];
  logic [31:0] model_log [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign im_dout = imem[im_addr[ADDR_W-1:2]];

  ifetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_addr        (im_addr),
    .im_dout        (im_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .misalign_err   (misalign_err)
  );

  // Drive one cycle of inputs, advance the reference model across the edge.
  task automatic step(input logic rst, input logic redir,
                      input logic [31:0] rpc, input logic rdy);
    bit do_pop;
    bit do_push;
    rst_n          = rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    if (rst && instr_valid && instr_ready) dut_log.push_back(instr_pc);
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_pc  = RESET_PC;
      m_mis = 1'b0;
    end else begin
      do_pop  = (mq.size() > 0) && rdy;
      do_push = !redir && ((mq.size() < DEPTH) || do_pop);
      m_mis   = redir && (rpc[1:0] != 2'b00);
      if (do_pop) begin
        model_log.push_back(mq[0].pc);
        void'(mq.pop_front());
      end
      if (redir) begin
        mq.delete();
        m_pc = {rpc[31:2], 2'b00};
      end else if (do_push) begin
        mq.push_back('{pc: m_pc, word: imem[m_pc[13:2]]});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", instr_valid);
    end
    checks++;
    if (im_addr !== RESET_PC[ADDR_W-1:0]) begin
      errors++; $display("FAIL reset_im_addr got %h want %h", im_addr, RESET_PC[ADDR_W-1:0]);
    end
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++; $display("FAIL reset_misalign got %b want 0", misalign_err);
    end
    checks++;
    if ($isunknown({instr, instr_pc})) begin
      errors++; $display("FAIL reset_no_x got %h/%h want known", instr, instr_pc);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    test_reset();
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'hffe18113}) begin
      errors++;
      $display("FAIL stream_first got v=%b pc=%h i=%h want v=1 pc=0 i=ffe18113",
               instr_valid, instr_pc, instr);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h4, 32'hfff18a13}) begin
      errors++;
      $display("FAIL stream_second got v=%b pc=%h i=%h want v=1 pc=4 i=fff18a13",
               instr_valid, instr_pc, instr);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      exp_pc = 32'h8 + 32'(4 * i);
      checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, imem[exp_pc[13:2]]}) begin
        errors++;
        $display("FAIL stream_rate got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                 instr_valid, instr_pc, instr, exp_pc, imem[exp_pc[13:2]]);
      end
    end
  endtask

  task automatic test_backpressure();
    test_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'hffe18113}) begin
        errors++;
        $display("FAIL hold_head got v=%b pc=%h i=%h want v=1 pc=0 i=ffe18113",
                 instr_valid, instr_pc, instr);
      end
    end
    checks++;
    if (im_addr !== 14'h0008) begin
      errors++; $display("FAIL hold_im_addr got %h want 0008", im_addr);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h4}) begin
      errors++; $display("FAIL release_pc4 got v=%b pc=%h want v=1 pc=4", instr_valid, instr_pc);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h8}) begin
      errors++; $display("FAIL release_pc8 got v=%b pc=%h want v=1 pc=8", instr_valid, instr_pc);
    end
  endtask

  task automatic test_redirect_full();
    test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_00a0, 1'b0);
    checks++;
    if ({instr_valid, im_addr} !== {1'b0, 14'h00a0}) begin
      errors++; $display("FAIL redir_bubble got v=%b a=%h want v=0 a=00a0", instr_valid, im_addr);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'ha0, 32'h00218293}) begin
      errors++;
      $display("FAIL redir_a0 got v=%b pc=%h i=%h want v=1 pc=a0 i=00218293",
               instr_valid, instr_pc, instr);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'ha4, 32'h00008297}) begin
      errors++;
      $display("FAIL redir_a4 got v=%b pc=%h i=%h want v=1 pc=a4 i=00008297",
               instr_valid, instr_pc, instr);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'ha8, 32'h0}) begin
      errors++;
      $display("FAIL past_end got v=%b pc=%h i=%h want v=1 pc=a8 i=0",
               instr_valid, instr_pc, instr);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({instr_valid, instr_pc, misalign_err} !== {1'b1, 32'hac, 1'b0}) begin
      errors++;
      $display("FAIL past_end_next got v=%b pc=%h m=%b want v=1 pc=ac m=0",
               instr_valid, instr_pc, misalign_err);
    end
  endtask

  task automatic test_misalign();
    step(1'b1, 1'b1, 32'h0000_007e, 1'b1);
    checks++;
    if ({misalign_err, instr_valid, im_addr} !== {1'b1, 1'b0, 14'h007c}) begin
      errors++;
      $display("FAIL misalign_pulse got m=%b v=%b a=%h want m=1 v=0 a=007c",
               misalign_err, instr_valid, im_addr);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({misalign_err, instr_valid, instr_pc, instr} !== {1'b0, 1'b1, 32'h7c, 32'h00018293}) begin
      errors++;
      $display("FAIL misalign_resume got m=%b v=%b pc=%h i=%h want m=0 v=1 pc=7c i=00018293",
               misalign_err, instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    checks++;
    if (im_addr !== 14'h3FF8) begin
      errors++; $display("FAIL wrap_addr got %h want 3ff8", im_addr);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL wrap_top got v=%b pc=%h want v=1 pc=fffffffc", instr_valid, instr_pc);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'hffe18113}) begin
      errors++;
      $display("FAIL wrap_zero got v=%b pc=%h i=%h want v=1 pc=0 i=ffe18113",
               instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_redirect_pop();
    logic [31:0] exp_log [4];
    exp_log = '{32'h0, 32'h40, 32'h44, 32'h48};
    test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    dut_log.delete();
    step(1'b1, 1'b1, 32'h0000_0040, 1'b1);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL rpop_bubble got v=%b want 0", instr_valid);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (dut_log.size() != 4) begin
      errors++; $display("FAIL rpop_count got %0d want 4", dut_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dut_log[i] !== exp_log[i]) begin
          errors++; $display("FAIL rpop_seq[%0d] got %h want %h", i, dut_log[i], exp_log[i]);
        end
      end
    end
    step(1'b0, 1'b1, 32'h0000_0082, 1'b1);
    checks++;
    if ({instr_valid, im_addr, misalign_err} !== {1'b0, 14'h0, 1'b0}) begin
      errors++;
      $display("FAIL midrst got v=%b a=%h m=%b want v=0 a=0000 m=0",
               instr_valid, im_addr, misalign_err);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({instr_valid, instr_pc, misalign_err} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_resume got v=%b pc=%h m=%b want v=1 pc=0 m=0",
               instr_valid, instr_pc, misalign_err);
    end
  endtask

  task automatic test_random();
    logic        r_rst;
    logic        r_redir;
    logic [31:0] r_pc;
    test_reset();
    dut_log.delete();
    model_log.delete();
    for (int i = 0; i < 400; i++) begin
      r_rst   = ($urandom_range(99) >= 2);
      r_redir = ($urandom_range(99) < 10);
      r_pc    = ($urandom_range(9) == 0) ? $urandom : ($urandom & 32'h0000_00ff);
      step(r_rst, r_redir, r_pc, ($urandom_range(99) < 70));
      checks++;
      if (instr_valid !== (mq.size() > 0)) begin
        errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, instr_valid, mq.size() > 0);
      end else if (mq.size() > 0) begin
        checks++;
        if ({instr_pc, instr} !== {mq[0].pc, mq[0].word}) begin
          errors++;
          $display("FAIL rnd_head cyc %0d got pc=%h i=%h want pc=%h i=%h",
                   i, instr_pc, instr, mq[0].pc, mq[0].word);
        end
      end
      checks++;
      if (im_addr !== m_pc[ADDR_W-1:0]) begin
        errors++; $display("FAIL rnd_addr cyc %0d got %h want %h", i, im_addr, m_pc[ADDR_W-1:0]);
      end
      checks++;
      if (misalign_err !== m_mis) begin
        errors++; $display("FAIL rnd_misalign cyc %0d got %b want %b", i, misalign_err, m_mis);
      end
      checks++;
      if ($isunknown({instr, instr_pc})) begin
        errors++; $display("FAIL rnd_no_x cyc %0d got %h/%h want known", i, instr, instr_pc);
      end
    end
    checks++;
    if (dut_log.size() != model_log.size()) begin
      errors++; $display("FAIL rnd_pops got %0d want %0d", dut_log.size(), model_log.size());
    end else begin
      for (int i = 0; i < dut_log.size(); i++) begin
        checks++;
        if (dut_log[i] !== model_log[i]) begin
          errors++; $display("FAIL rnd_pop_pc[%0d] got %h want %h", i, dut_log[i], model_log[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) imem[i] = 32'h0;
    for (int i = 0; i < 42; i++) imem[i] = $urandom;
    imem[0]  = 32'hffe18113;
    imem[1]  = 32'hfff18a13;
    imem[31] = 32'h00018293;
    imem[40] = 32'h00218293;
    imem[41] = 32'h00008297;
    m_pc  = RESET_PC;
    m_mis = 1'b0;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misalign();
    test_wrap();
    test_redirect_pop();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
